// File: rtl/serial_driver_pkg.sv
// Shared types and elaboration helpers for serial_display_driver: FSM state
// encoding, shift-clock divider calculation and legal parameter bounds.
package serial_driver_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int DIGITS_MIN   = 1;
    localparam int DIGITS_MAX   = 16;
    localparam int SEG_BITS_MIN = 1;
    localparam int SEG_BITS_MAX = 16;

    // System cycles per shift-clock half period; 0 means the requested rate is unreachable.
    function automatic int calc_half(input int sys_clk_hz, input int shift_clk_hz);
        if (shift_clk_hz <= 0) begin
            return 0;
        end
        return sys_clk_hz / (2 * shift_clk_hz);
    endfunction

endpackage

// File: rtl/pwm_dimmer.sv
// Free-running PWM generator for the display chain's active-low output enable.
// Only compiled when SERIAL_DRIVER_DIM_EN is defined.
`ifdef SERIAL_DRIVER_DIM_EN
module pwm_dimmer #(
    parameter int BRIGHT_BITS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [BRIGHT_BITS-1:0] i_brightness,
    output logic                   o_oe_n
);

    logic [BRIGHT_BITS-1:0] r_cnt;
    logic                   r_oe_n;

    // Brightness 0 never enables the chain; the maximum code leaves one dark slot per period.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt  <= '0;
            r_oe_n <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_oe_n <= !(r_cnt < i_brightness);
        end
    end

    assign o_oe_n = r_oe_n;

endmodule
`endif

// File: rtl/serial_display_driver.sv
// Frame serializer for a data/clock/latch shift-register display chain.
// Define SERIAL_DRIVER_DIM_EN to add PWM brightness control on o_serial_oe_n.
module serial_display_driver
    import serial_driver_pkg::*;
#(
    parameter int SYS_CLK_HZ   = 5_000_000,
    parameter int SHIFT_CLK_HZ = 1_000_000,
    parameter int NUM_DIGITS   = 4,
    parameter int SEG_BITS     = 8,
    parameter bit MSB_FIRST    = 1'b1
`ifdef SERIAL_DRIVER_DIM_EN
    ,
    parameter int BRIGHT_BITS  = 4
`endif
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_en,
    input  logic [NUM_DIGITS*SEG_BITS-1:0] i_frame,
    input  logic                           i_valid,
`ifdef SERIAL_DRIVER_DIM_EN
    input  logic [BRIGHT_BITS-1:0]         i_brightness,
    output logic                           o_serial_oe_n,
`endif
    output logic                           o_ready,
    output logic                           o_serial_data,
    output logic                           o_serial_clk,
    output logic                           o_serial_latch
);

    localparam int TOTAL = NUM_DIGITS * SEG_BITS;
    localparam int HALF  = calc_half(SYS_CLK_HZ, SHIFT_CLK_HZ);
    localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BIT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    if (HALF < 1) begin : g_half_check
        $error("serial_display_driver: SHIFT_CLK_HZ too high for SYS_CLK_HZ (HALF == 0)");
    end
    if (NUM_DIGITS < DIGITS_MIN || NUM_DIGITS > DIGITS_MAX) begin : g_digits_check
        $error("serial_display_driver: NUM_DIGITS out of range");
    end
    if (SEG_BITS < SEG_BITS_MIN || SEG_BITS > SEG_BITS_MAX) begin : g_seg_check
        $error("serial_display_driver: SEG_BITS out of range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PH_W-1:0]    r_phase;
    logic [BIT_W-1:0]   r_bit;
    logic [TOTAL-1:0]   r_shift;
    logic [TOTAL-1:0]   w_shift_nxt;

    logic               w_accept;
    logic               w_phase_done;
    logic               w_last_bit;
    logic               w_head_bit;

    logic               r_data;
    logic               r_sclk;
    logic               r_latch;
    logic               w_data_nxt;
    logic               w_sclk_nxt;
    logic               w_latch_nxt;

    assign o_ready      = (r_state == IDLE) && i_en;
    assign w_accept     = o_ready && i_valid;
    assign w_phase_done = (r_phase == PH_W'(HALF - 1));
    assign w_last_bit   = (r_bit == BIT_W'(TOTAL - 1));

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;

            if (r_state == IDLE || w_state_nxt != r_state) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end

            if (w_accept) begin
                r_bit <= '0;
            end else if (r_state == SHIFT_HI && w_phase_done && !w_last_bit) begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (w_phase_done) begin
                    w_state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_phase_done) begin
                    w_state_nxt = w_last_bit ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (w_phase_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The frame is captured only at acceptance; it advances as each rising clock phase ends.
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = i_frame;
        end else if (r_state == SHIFT_HI && w_phase_done) begin
            w_shift_nxt = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
        end
    end

    assign w_head_bit = MSB_FIRST ? w_shift_nxt[TOTAL-1] : w_shift_nxt[0];

    // ---------------------------------------------------------------- outputs
    // Outputs are decoded from the next state and registered, so pins change
    // together with the state they belong to and never glitch.
    always_comb begin
        w_data_nxt  = 1'b0;
        w_sclk_nxt  = 1'b0;
        w_latch_nxt = 1'b0;
        unique case (w_state_nxt)
            SHIFT_LO: begin
                w_data_nxt = w_head_bit;
            end
            SHIFT_HI: begin
                w_data_nxt = w_head_bit;
                w_sclk_nxt = 1'b1;
            end
            LATCH: begin
                w_latch_nxt = 1'b1;
            end
            default: begin
                w_data_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data  <= 1'b0;
            r_sclk  <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_data  <= w_data_nxt;
            r_sclk  <= w_sclk_nxt;
            r_latch <= w_latch_nxt;
        end
    end

    assign o_serial_data  = r_data;
    assign o_serial_clk   = r_sclk;
    assign o_serial_latch = r_latch;

`ifdef SERIAL_DRIVER_DIM_EN
    pwm_dimmer #(
        .BRIGHT_BITS (BRIGHT_BITS)
    ) u_pwm_dimmer (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_brightness (i_brightness),
        .o_oe_n       (o_serial_oe_n)
    );
`else
    // Output enable of the chain is tied externally in this build.
`endif

endmodule

// File: tb/tb_serial_display_driver.sv
// Directed bench for serial_display_driver: a default 4x8 MSB-first instance
// and a 2x7 LSB-first instance share clock, reset and enable.
`timescale 1ns/1ps
module tb_serial_display_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;

    logic [31:0] a_frame = '0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_data, a_sclk, a_latch;

    logic [13:0] b_frame = '0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_data, b_sclk, b_latch;

`ifdef SERIAL_DRIVER_DIM_EN
    logic [3:0]  a_bright = '0;
    logic [3:0]  b_bright = '0;
    logic        a_oe_n, b_oe_n;
`endif

    int          n_vectors = 0;
    int          n_miscompares = 0;
    int          sel = 0;
    logic        s_ready, s_data, s_sclk, s_latch;

    always #5 clk = ~clk;

    serial_display_driver u_dut_a (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_en           (en),
        .i_frame        (a_frame),
        .i_valid        (a_valid),
`ifdef SERIAL_DRIVER_DIM_EN
        .i_brightness   (a_bright),
        .o_serial_oe_n  (a_oe_n),
`endif
        .o_ready        (a_ready),
        .o_serial_data  (a_data),
        .o_serial_clk   (a_sclk),
        .o_serial_latch (a_latch)
    );

    serial_display_driver #(
        .NUM_DIGITS (2),
        .SEG_BITS   (7),
        .MSB_FIRST  (1'b0)
    ) u_dut_b (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_en           (en),
        .i_frame        (b_frame),
        .i_valid        (b_valid),
`ifdef SERIAL_DRIVER_DIM_EN
        .i_brightness   (b_bright),
        .o_serial_oe_n  (b_oe_n),
`endif
        .o_ready        (b_ready),
        .o_serial_data  (b_data),
        .o_serial_clk   (b_sclk),
        .o_serial_latch (b_latch)
    );

    always_comb begin
        s_ready = (sel == 0) ? a_ready : b_ready;
        s_data  = (sel == 0) ? a_data  : b_data;
        s_sclk  = (sel == 0) ? a_sclk  : b_sclk;
        s_latch = (sel == 0) ? a_latch : b_latch;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel == 0) a_valid = v;
        else          b_valid = v;
    endtask

    // Offers (unless already offered) one frame on the selected instance and
    // observes it until the latch pulse ends, checking bits and timing.
    task automatic run_frame(input string tag, input int total, input bit msb_first,
                             input logic [31:0] frame, input bit offered,
                             input bit hold_valid, input logic [31:0] next_frame,
                             input int pulse_at, input int drop_en_at, input int exp_ready_low);
        int          cycles = 0;
        int          rises = 0;
        int          latch_cycles = 0;
        int          timing_err = 0;
        logic        prev_sclk = 1'b0;
        logic        prev_data = 1'b0;
        logic [31:0] got = '0;
        logic [31:0] exp_seq = '0;
        logic        b;

        for (int i = 0; i < total; i++) begin
            b = msb_first ? frame[total-1-i] : frame[i];
            exp_seq = {exp_seq[30:0], b};
        end

        if (!offered) begin
            if (sel == 0) a_frame = frame;
            else          b_frame = frame[13:0];
            set_valid(1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) begin
            if (sel == 0) a_frame = next_frame;
            else          b_frame = next_frame[13:0];
        end else begin
            set_valid(1'b0);
        end

        while (cycles < 1000) begin
            if (s_ready || (latch_cycles > 0 && !s_latch)) break;
            if (cycles == pulse_at)     set_valid(1'b1);
            if (cycles == pulse_at + 1) set_valid(1'b0);
            if (cycles == drop_en_at)   en = 1'b0;
            if (s_sclk && !prev_sclk) begin
                rises++;
                got = {got[30:0], s_data};
                if (s_data !== prev_data) timing_err++;
            end
            if (s_sclk && prev_sclk && s_data !== prev_data) timing_err++;
            if (s_latch) begin
                if (latch_cycles == 0 && !(prev_sclk && !s_sclk)) timing_err++;
                if (s_data !== 1'b0) timing_err++;
                latch_cycles++;
            end
            prev_sclk = s_sclk;
            prev_data = s_data;
            cycles++;
            @(negedge clk);
        end

        check({tag, "_ready_low"}, 32'(cycles), 32'(exp_ready_low));
        check({tag, "_clk_rises"}, 32'(rises), 32'(total));
        check({tag, "_bits"}, got, exp_seq);
        check({tag, "_latch_len"}, 32'(latch_cycles), 32'd2);
        check({tag, "_timing"}, 32'(timing_err), 32'd0);
    endtask

    initial begin
        int          highs;
        int          latches;
        logic [31:0] f;

        // Reset state
        #2;
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_clk", 32'(a_sclk), 32'd0);
        check("rst_latch", 32'(a_latch), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Default instance, MSB first: (2*32+1)*2 = 130 busy cycles
        sel = 0;
        run_frame("a_msb", 32, 1'b1, 32'hA5_3C_0F_81, 1'b0, 1'b0, '0, -10, -10, 130);

        // 2x7 LSB-first instance: (2*14+1)*2 = 58 busy cycles
        sel = 1;
        run_frame("b_lsb", 14, 1'b0, 32'h0000_2AB3, 1'b0, 1'b0, '0, -10, -10, 58);

        // Back-to-back with i_valid held; the frame bus changes mid-flight
        sel = 0;
        run_frame("b2b_1", 32, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'hC0FF_EE01, -10, -10, 130);
        run_frame("b2b_2", 32, 1'b1, 32'hC0FF_EE01, 1'b1, 1'b0, '0, -10, -10, 130);

        // i_valid pulse while busy is ignored
        a_frame = 32'hFFFF_FFFF;
        run_frame("busy", 32, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, '0, 20, -10, 130);
        highs = 0;
        latches = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_sclk) highs++;
            if (a_latch) latches++;
        end
        check("busy_no_restart", 32'(highs + latches), 32'd0);
        check("busy_ready", 32'(a_ready), 32'd1);

        // i_en low blocks acceptance
        en = 1'b0;
        a_frame = 32'hFFFF_FFFF;
        a_valid = 1'b1;
        highs = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_sclk || a_latch) highs++;
        end
        check("en0_ready", 32'(a_ready), 32'd0);
        check("en0_idle", 32'(highs), 32'd0);
        a_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);

        // i_en dropped mid-frame: frame and latch still complete
        run_frame("en_drop", 32, 1'b1, 32'h0F0F_3355, 1'b0, 1'b0, '0, -10, 10, 130);
        check("en_drop_ready", 32'(a_ready), 32'd0);
        en = 1'b1;
        @(negedge clk);
        check("en_back_ready", 32'(a_ready), 32'd1);

        // Asynchronous reset while bit 10 is on the wire
        f = 32'hDEAD_BEEF;
        a_frame = f;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (41) @(negedge clk);
        check("pre_rst_bit10", 32'(a_data), 32'(f[21]));
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(a_data), 32'd0);
        check("mid_rst_clk", 32'(a_sclk), 32'd0);
        latches = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_latch) latches++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (a_latch) latches++;
        end
        check("mid_rst_no_latch", 32'(latches), 32'd0);
        check("mid_rst_ready", 32'(a_ready), 32'd1);
        run_frame("post_rst", 32, 1'b1, 32'h5A5A_C3C3, 1'b0, 1'b0, '0, -10, -10, 130);

`ifdef SERIAL_DRIVER_DIM_EN
        a_bright = 4'd4;
        repeat (20) @(negedge clk);
        highs = 0;
        repeat (32) begin
            @(negedge clk);
            if (!a_oe_n) highs++;
        end
        check("dim_4of16", 32'(highs), 32'd8);
        a_bright = 4'd0;
        repeat (20) @(negedge clk);
        highs = 0;
        repeat (32) begin
            @(negedge clk);
            if (!a_oe_n) highs++;
        end
        check("dim_off", 32'(highs), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/serial_display_driver.md
# serial_display_driver

Parametrised serializer that pushes a multi-digit segment frame into an external chain of shift registers (data/clock/latch), replacing the fixed-function serial output path of the digital clock. It sits between the display encoder and the `uo_out` serial pins. It accepts one frame per valid/ready handshake, shifts it out at a divided shift clock, then pulses the latch so the display updates atomically.

## Interface
- `SYS_CLK_HZ`, 5_000_000: system clock frequency.
- `SHIFT_CLK_HZ`, 1_000_000: target shift clock; actual rate set by HALF below.
- `NUM_DIGITS`, 4: digits in the chain, 1..16.
- `SEG_BITS`, 8: bits per digit, 1..16.
- `MSB_FIRST`, 1: 1 = frame bit [TOTAL-1] shifted first; 0 = bit [0] first.
- `i_clk`  in  1  system clock; single clock domain.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_en`  in  1  block enable; gates frame acceptance only.
- `i_frame`  in  NUM_DIGITS*SEG_BITS  frame; digit d at bits [d*SEG_BITS +: SEG_BITS].
- `i_valid`  in  1  frame offered.
- `o_ready`  out  1  block idle and enabled; combinational (state==IDLE && i_en).
- `o_serial_data`  out  1  serial data to chain.
- `o_serial_clk`  out  1  shift clock; chain samples on rising edge.
- `o_serial_latch`  out  1  storage latch pulse, active high.

## Operation
- TOTAL = NUM_DIGITS*SEG_BITS; HALF = SYS_CLK_HZ/(2*SHIFT_CLK_HZ), integer division; HALF==0 is an elaboration error. Defaults give HALF=2 (1.25 MHz actual).
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH. Phase counter counts HALF cycles per state; bit counter counts 0..TOTAL-1.
- IDLE: accept when i_valid && o_ready on a rising edge; capture i_frame into shift register, bit counter=0, go SHIFT_LO.
- SHIFT_LO (HALF cycles): clk=0, data = current bit, registered, stable for whole phase; then SHIFT_HI.
- SHIFT_HI (HALF cycles): clk=1, data held; at exit shift register advances; if last bit go LATCH else SHIFT_LO.
- LATCH (HALF cycles): clk=0, latch=1, data=0; then IDLE.
- i_valid while busy is ignored; no queueing. Frame contents sampled only at acceptance.
- i_en deasserted mid-frame: frame completes normally; no new frame accepted until i_en returns.
- Reset (any time, including mid-frame): state IDLE, all outputs 0, shift/counter registers 0; partial frame discarded, latch never pulses, so display retains previous content.
- Reset values: o_serial_data=0, o_serial_clk=0, o_serial_latch=0; o_ready = i_en.

## Timing
- Acceptance edge = cycle 0; first bit on o_serial_data and SHIFT_LO entered from cycle 1 output.
- Each o_serial_clk period = 2*HALF cycles; data changes only on SHIFT_LO entry (HALF cycles of setup before rising clk edge).
- o_ready low for exactly (2*TOTAL+1)*HALF cycles; latch high for HALF cycles, immediately after final clk fall.
- Back-to-back: i_valid held high accepts the next frame on the first cycle o_ready is high; zero idle cycles between frames.

## Configuration
- `SERIAL_DRIVER_DIM_EN` defined: adds parameter `BRIGHT_BITS` (default 4), input `i_brightness` [BRIGHT_BITS-1:0], output `o_serial_oe_n`. Free-running BRIGHT_BITS counter at i_clk; o_serial_oe_n = !(cnt < i_brightness) registered; 0 = dark, max = (2^B-1)/2^B duty. Reset value of o_serial_oe_n = 1. Independent of FSM.
- Undefined: those ports/parameter absent; display output enable is tied externally.

## Structure
- Package `serial_driver_pkg`: FSM state enum, `calc_half()` function for HALF, bounds constants for NUM_DIGITS/SEG_BITS.
- Sub-module `pwm_dimmer` (only instantiated under the macro); FSM, phase counter and shift register stay in the top module.

## Test plan
- Defaults, i_frame=32'hA5_3C_0F_81, MSB_FIRST=1 -> 32 rising clk edges sampling 1010_0101..1000_0001, latch high 2 cycles, o_ready low exactly 130 cycles.
- MSB_FIRST=0, NUM_DIGITS=2, SEG_BITS=7, frame 14'h2AB3 -> bits sent LSB first, 14 clk edges, o_ready low (29)*2=58 cycles.
- i_valid held high with two frames -> second accepted on the first cycle o_ready is high; i_valid pulses while busy -> ignored, no extra latch.
- Assert i_reset_n low at bit 10 -> outputs 0 immediately (asynchronous), no latch pulse, o_ready = i_en on release; next frame sent complete.
- i_en=0 with i_valid=1 -> no acceptance, o_ready=0; i_en dropped mid-frame -> frame and latch complete.
- With SERIAL_DRIVER_DIM_EN, BRIGHT_BITS=4, i_brightness=4 -> o_serial_oe_n low 4 of every 16 cycles; i_brightness=0 -> constantly high.
